// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches into a 2-entry
// {pc, instruction} buffer, drains it towards decode, and handles
// redirects (branchTaken), halt requests and the HALT_ADDR sentinel.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_ADDR = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imemAddress,
  output logic        imemReadEnable,
  input  logic [31:0] imemDataIn,
  output logic [31:0] instrOut,
  output logic [31:0] pcOut,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        haltReq,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [1:0]  count_r;
  logic [1:0]  count_next_s;

  // Entry 0 is always the head; entry 1 is the tail when two are held.
  logic [31:0] e0_pc_r;
  logic [31:0] e0_instr_r;
  logic [31:0] e1_pc_r;
  logic [31:0] e1_instr_r;
  logic [31:0] e0_pc_next_s;
  logic [31:0] e0_instr_next_s;
  logic [31:0] e1_pc_next_s;
  logic [31:0] e1_instr_next_s;

  logic        valid_r;
  logic        halted_r;
  logic        pop_s;
  logic        issue_s;

  assign pop_s = valid_r & instrReady;

  // Fetch issue decision: room in the buffer (or a slot freed this cycle),
  // not halting, and not sitting on the sentinel address.
  always_comb begin
    issue_s = 1'b0;
    if ((state_r == ST_FETCH) && !haltReq && (pc_r != HALT_ADDR)) begin
      if ((count_r < 2'd2) || ((count_r == 2'd2) && pop_s)) begin
        issue_s = 1'b1;
      end else begin
        issue_s = 1'b0;
      end
    end else begin
      issue_s = 1'b0;
    end
  end

  assign imemReadEnable = issue_s;
  assign imemAddress    = issue_s ? pc_r : HALT_ADDR;

  // Next pc, buffer contents and occupancy; a redirect overrides push and pop.
  always_comb begin
    pc_next_s       = pc_r;
    count_next_s    = count_r;
    e0_pc_next_s    = e0_pc_r;
    e0_instr_next_s = e0_instr_r;
    e1_pc_next_s    = e1_pc_r;
    e1_instr_next_s = e1_instr_r;
    if (branchTaken) begin
      pc_next_s    = branchTarget;
      count_next_s = 2'd0;
    end else begin
      if (issue_s) begin
        pc_next_s = pc_r + 32'd1;
      end else begin
        pc_next_s = pc_r;
      end
      // Pop shifts the tail into the head slot.
      if (pop_s) begin
        e0_pc_next_s    = e1_pc_r;
        e0_instr_next_s = e1_instr_r;
      end else begin
        e0_pc_next_s    = e0_pc_r;
        e0_instr_next_s = e0_instr_r;
      end
      // Push lands in the first free slot after any same-cycle pop.
      if (issue_s) begin
        if ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s)) begin
          e0_pc_next_s    = pc_r;
          e0_instr_next_s = imemDataIn;
        end else begin
          e1_pc_next_s    = pc_r;
          e1_instr_next_s = imemDataIn;
        end
      end else begin
        e1_pc_next_s    = e1_pc_r;
        e1_instr_next_s = e1_instr_r;
      end
      case ({issue_s, pop_s})
        2'b10:   count_next_s = count_r + 2'd1;
        2'b01:   count_next_s = count_r - 2'd1;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Next-state logic; a redirect always lands in FETCH.
  always_comb begin
    state_next_s = state_r;
    if (branchTaken) begin
      state_next_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_FETCH;
        end
        ST_FETCH: begin
          if ((haltReq || (pc_r == HALT_ADDR)) && (count_next_s == 2'd0)) begin
            state_next_s = ST_HALTED;
          end else begin
            state_next_s = ST_FETCH;
          end
        end
        ST_HALTED: begin
          // Stay put while parked on the sentinel so halted does not toggle.
          if (!haltReq && (pc_r != HALT_ADDR)) begin
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_HALTED;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // pc, occupancy and buffer entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      count_r    <= 2'd0;
      e0_pc_r    <= 32'd0;
      e0_instr_r <= 32'd0;
      e1_pc_r    <= 32'd0;
      e1_instr_r <= 32'd0;
    end else begin
      pc_r       <= pc_next_s;
      count_r    <= count_next_s;
      e0_pc_r    <= e0_pc_next_s;
      e0_instr_r <= e0_instr_next_s;
      e1_pc_r    <= e1_pc_next_s;
      e1_instr_r <= e1_instr_next_s;
    end
  end

  // Registered status flags so decode sees glitch-free valid/halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      valid_r  <= (count_next_s != 2'd0);
      halted_r <= (state_next_s == ST_HALTED);
    end
  end

  assign instrOut   = e0_instr_r;
  assign pcOut      = e0_pc_r;
  assign instrValid = valid_r;
  assign halted     = halted_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: memory returns word[n]=n+100,
// expected pcs are queued as stimulus is driven and compared on each accept.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imemAddress;
  logic        imemReadEnable;
  logic [31:0] imemDataIn;
  logic [31:0] instrOut;
  logic [31:0] pcOut;
  logic        instrValid;
  logic        instrReady;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        haltReq;
  logic        halted;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] last_pc = 32'd0;
  logic [31:0] base;

  instruction_fetch_unit #(
    .RESET_PC (32'd0),
    .HALT_ADDR(32'hFFFFFFFF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imemAddress   (imemAddress),
    .imemReadEnable(imemReadEnable),
    .imemDataIn    (imemDataIn),
    .instrOut      (instrOut),
    .pcOut         (pcOut),
    .instrValid    (instrValid),
    .instrReady    (instrReady),
    .branchTaken   (branchTaken),
    .branchTarget  (branchTarget),
    .haltReq       (haltReq),
    .halted        (halted)
  );

  // Instruction memory model.
  assign imemDataIn = imemAddress + 32'd100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_seq(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(i));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    check_eq("drain_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    instrReady = 1'b0;
  endtask

  task automatic fill_two();
    instrReady = 1'b0;
    cyc(); cyc(); cyc();
    check_eq("fill_valid", {31'd0, instrValid}, 32'd1);
    check_eq("fill_head_pc", pcOut, last_pc + 32'd1);
    check_eq("fill_rden", {31'd0, imemReadEnable}, 32'd0);
    check_eq("fill_addr", imemAddress, 32'hFFFFFFFF);
  endtask

  task automatic do_branch(input logic [31:0] tgt, input int n);
    instrReady   = 1'b0;
    branchTarget = tgt;
    branchTaken  = 1'b1;
    cyc();
    branchTaken  = 1'b0;
    #1;
    check_eq("br_valid", {31'd0, instrValid}, 32'd0);
    check_eq("br_halted", {31'd0, halted}, 32'd0);
    check_eq("br_rden", {31'd0, imemReadEnable}, 32'd1);
    check_eq("br_addr", imemAddress, tgt);
    push_seq(tgt, n);
    cyc();
    check_eq("br_pcout", pcOut, tgt);
    check_eq("br_instr", instrOut, tgt + 32'd100);
    instrReady = 1'b1;
  endtask

  // Scoreboard and address invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imemReadEnable) begin
        check_eq("issue_not_halt", {31'd0, imemAddress != 32'hFFFFFFFF}, 32'd1);
      end else begin
        check_eq("idle_addr", imemAddress, 32'hFFFFFFFF);
      end
      if (instrValid && instrReady) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq("sb_pc", pcOut, mon_exp);
          check_eq("sb_instr", instrOut, mon_exp + 32'd100);
          last_pc = mon_exp;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    instrReady   = 1'b1;
    branchTaken  = 1'b0;
    branchTarget = 32'd0;
    haltReq      = 1'b0;
    #3;
    check_eq("rst_valid", {31'd0, instrValid}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_rden", {31'd0, imemReadEnable}, 32'd0);
    check_eq("rst_addr", imemAddress, 32'hFFFFFFFF);
    check_eq("rst_instr", instrOut, 32'd0);
    check_eq("rst_pc", pcOut, 32'd0);

    // Streaming from reset with decode always ready.
    push_seq(32'd0, 8);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc();
    check_eq("s1_e1_valid", {31'd0, instrValid}, 32'd0);
    check_eq("s1_e1_addr", imemAddress, 32'd0);
    cyc();
    check_eq("s1_e2_valid", {31'd0, instrValid}, 32'd1);
    check_eq("s1_e2_pc", pcOut, 32'd0);
    check_eq("s1_e2_instr", instrOut, 32'd100);
    drain();

    // Backpressure, then asynchronous reset with a full buffer.
    fill_two();
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, instrValid}, 32'd0);
    check_eq("arst_pc", pcOut, 32'd0);
    check_eq("arst_rden", {31'd0, imemReadEnable}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    check_eq("bp_valid", {31'd0, instrValid}, 32'd1);
    check_eq("bp_pc", pcOut, 32'd0);
    check_eq("bp_instr", instrOut, 32'd100);
    check_eq("bp_rden", {31'd0, imemReadEnable}, 32'd0);
    check_eq("bp_addr", imemAddress, 32'hFFFFFFFF);
    push_seq(32'd0, 4);
    instrReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("bp_nogap", {31'd0, instrValid}, 32'd1);
    end
    drain();

    // Redirect with a full buffer.
    fill_two();
    do_branch(32'd10, 3);
    drain();

    // Halt request with a full buffer, then resume.
    fill_two();
    base    = last_pc + 32'd1;
    push_seq(base, 2);
    haltReq    = 1'b1;
    instrReady = 1'b1;
    #1;
    check_eq("halt_no_issue", {31'd0, imemReadEnable}, 32'd0);
    for (int i = 0; i < 8 && !halted; i++) begin
      cyc();
      check_eq("halt_no_issue", {31'd0, imemReadEnable}, 32'd0);
    end
    check_eq("halt_flag", {31'd0, halted}, 32'd1);
    check_eq("halt_drained", 32'(exp_q.size()), 32'd0);
    check_eq("halt_valid", {31'd0, instrValid}, 32'd0);
    cyc();
    check_eq("halt_hold", {31'd0, halted}, 32'd1);
    haltReq = 1'b0;
    cyc();
    check_eq("resume_halted", {31'd0, halted}, 32'd0);
    check_eq("resume_rden", {31'd0, imemReadEnable}, 32'd1);
    check_eq("resume_addr", imemAddress, base + 32'd2);
    push_seq(base + 32'd2, 3);
    drain();

    // Run into the sentinel address, then redirect out of HALTED.
    fill_two();
    do_branch(32'hFFFFFFFD, 2);
    for (int i = 0; i < 8 && !halted; i++) cyc();
    check_eq("sent_halted", {31'd0, halted}, 32'd1);
    check_eq("sent_drained", 32'(exp_q.size()), 32'd0);
    check_eq("sent_last", last_pc, 32'hFFFFFFFE);
    cyc(); cyc();
    check_eq("sent_hold", {31'd0, halted}, 32'd1);
    check_eq("sent_rden", {31'd0, imemReadEnable}, 32'd0);
    do_branch(32'd4, 3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'd0, giving the word address of the first fetch after reset.
REQ-002 The block SHALL have parameter HALT_ADDR, default 32'hFFFFFFFF, the idle/sentinel address, which is never issued as a read.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 imemAddress  output  32  word address driven to instruction memory.
REQ-006 imemReadEnable  output  1  high when imemAddress is a real fetch.
REQ-007 imemDataIn  input  32  instruction word returned combinationally for imemAddress in the same cycle.
REQ-008 instrOut  output  32  instruction at buffer head.
REQ-009 pcOut  output  32  word address of instrOut.
REQ-010 instrValid  output  1  buffer head holds a valid instruction.
REQ-011 instrReady  input  1  decode accepts head when instrValid is high.
REQ-012 branchTaken  input  1  redirect request, one-cycle pulse.
REQ-013 branchTarget  input  32  redirect word address, sampled with branchTaken.
REQ-014 haltReq  input  1  stop issuing new fetches.
REQ-015 halted  output  1  fetch stopped and buffer empty.

Function
REQ-016 The block SHALL keep a 2-entry FIFO of {pc, instruction} pairs plus a 2-bit count; instrOut/pcOut SHALL be the head entry, instrValid = (count != 0).
REQ-017 States SHALL be IDLE, FETCH, HALTED; IDLE -> FETCH on the first clock edge after reset deassertion.
REQ-018 In FETCH, a fetch SHALL issue (imemReadEnable=1, imemAddress=pc) when count<2, or count==2 and a pop occurs in the same cycle; otherwise imemReadEnable=0.
REQ-019 Whenever imemReadEnable=0, imemAddress SHALL be HALT_ADDR.
REQ-020 An issued fetch SHALL push {pc, imemDataIn} at the next edge and increment pc by 1 (wraps mod 2^32), so an instruction is visible on instrOut one cycle after issue.
REQ-021 Pop SHALL occur when instrValid && instrReady; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-022 If pc == HALT_ADDR in FETCH, no fetch SHALL issue and state SHALL go to HALTED after the buffer drains.
REQ-023 branchTaken SHALL have priority over all other events: at that edge the FIFO is flushed (count=0), pc=branchTarget, any same-cycle push and pop are discarded, and state becomes FETCH (including from HALTED); instrValid SHALL be 0 in the following cycle.
REQ-024 haltReq high in FETCH SHALL suppress issue in that cycle; state SHALL become HALTED once count==0; buffered entries SHALL still drain normally.
REQ-025 halted SHALL be 1 only in HALTED; deasserting haltReq in HALTED SHALL resume FETCH at the held pc on the next edge.
REQ-026 Outputs SHALL be glitch-free registered values except imemAddress/imemReadEnable, which are combinational from state, pc, count and the pop condition.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, pc=RESET_PC, count=0, FIFO entries=0, instrOut=0, pcOut=0, instrValid=0, halted=0, imemReadEnable=0, imemAddress=HALT_ADDR.
REQ-028 Reset asserted mid-operation SHALL discard all buffered instructions and any pending redirect.

Verification
REQ-029 Reset release, instrReady=1, memory preloaded word[n]=n+100 -> edge1 IDLE->FETCH, edge2 instrOut=100/pcOut=0, then one instruction per cycle, pcOut 1,2,3...
REQ-030 instrReady=0 from the start -> exactly 2 entries buffered (pc 0,1), imemReadEnable=0, imemAddress=32'hFFFFFFFF; raising instrReady delivers pc 0,1,2 in order with no gap.
REQ-031 branchTaken with branchTarget=32'd10 while count=2 -> next cycle instrValid=0, imemAddress=10; the cycle after, pcOut=10; old entries never appear.
REQ-032 haltReq=1 with count=2, instrReady=1 -> two more instructions delivered, then halted=1, imemReadEnable=0; haltReq=0 resumes at pc+2.
REQ-033 pc reaches 32'hFFFFFFFF -> that address is never issued, halted=1 after drain; branchTaken to 32'd4 resumes, pcOut=4.
REQ-034 rst_n pulsed low while count=2 -> instrValid=0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
